// File: rtl/mo_arb.sv
// mo_arb: round-robin arbiter/sequencer for the five-input grant-selected
// output mixer. It issues a registered one-hot grant and holds it until the
// owner signals last, drops its request, or the watchdog expires. There is
// always one all-zero grant cycle between owners.
//
// Ports:
//   wb_clk_i   in   clock, rising edge
//   wb_rst_i   in   synchronous active-high reset
//   req[4:0]   in   per-requester request level
//   last[4:0]  in   per-requester final-cycle strobe (owner bit only)
//   gnt[4:0]   out  registered one-hot grant, zero between owners
//   gnt_valid  out  registered copy of |gnt
//   gnt_id[2:0]out  encoded owner index, held while gnt is zero
//   tmo_o      out  one-cycle pulse on a watchdog-forced release
//   tmo_id[2:0]out  owner index of the most recent timeout
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | no owner; arbitrate every cycle
// BUSY  | grant held; watch last/req of the owner and the watchdog
// GAP   | single zero-grant hand-over cycle; arbitrate
module mo_arb #(
  parameter int                 TMO_W = 8,
  parameter logic [TMO_W-1:0]   TMO   = 8'd255
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic [4:0] req,
  input  logic [4:0] last,
  output logic [4:0] gnt,
  output logic       gnt_valid,
  output logic [2:0] gnt_id,
  output logic       tmo_o,
  output logic [2:0] tmo_id
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [TMO_W-1:0] TMO_M1 = TMO - TMO_W'(1);

  state_t           state, state_nx;
  logic [2:0]       ptr, ptr_nx;
  logic [TMO_W-1:0] cnt, cnt_nx;
  logic [4:0]       gnt_nx;
  logic [2:0]       gnt_id_nx;
  logic             tmo_o_nx;
  logic [2:0]       tmo_id_nx;

  // Round-robin search starting one past the last owner.
  logic       found;
  logic [2:0] win;
  logic [2:0] idx;

  always_comb begin
    found = 1'b0;
    win   = 3'd0;
    idx   = ptr;
    for (int i = 0; i < 5; i++) begin
      idx = (idx == 3'd4) ? 3'd0 : idx + 3'd1;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  logic owner_done;
  logic tmo_hit;

  always_comb begin
    owner_done = last[gnt_id] | ~req[gnt_id];
    tmo_hit    = (TMO != '0) && (cnt == TMO_M1);
  end

  always_comb begin
    state_nx  = state;
    ptr_nx    = ptr;
    cnt_nx    = cnt;
    gnt_nx    = gnt;
    gnt_id_nx = gnt_id;
    tmo_o_nx  = 1'b0;
    tmo_id_nx = tmo_id;
    case (state)
      IDLE, GAP: begin
        if (found) begin
          state_nx  = BUSY;
          gnt_nx    = 5'(1) << win;
          gnt_id_nx = win;
          ptr_nx    = win;
          cnt_nx    = '0;
        end else begin
          state_nx = IDLE;
          gnt_nx   = 5'b0;
        end
      end
      BUSY: begin
        if (owner_done || tmo_hit) begin
          state_nx = GAP;
          gnt_nx   = 5'b0;
          // A normal release wins over a coincident watchdog expiry.
          if (!owner_done) begin
            tmo_o_nx  = 1'b1;
            tmo_id_nx = gnt_id;
          end
        end else if (cnt != TMO) begin
          cnt_nx = cnt + TMO_W'(1);
        end
      end
      default: begin
        state_nx = IDLE;
        gnt_nx   = 5'b0;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      ptr       <= 3'd4;
      cnt       <= '0;
      gnt       <= 5'b0;
      gnt_valid <= 1'b0;
      gnt_id    <= 3'd0;
      tmo_o     <= 1'b0;
      tmo_id    <= 3'd0;
    end else begin
      state     <= state_nx;
      ptr       <= ptr_nx;
      cnt       <= cnt_nx;
      gnt       <= gnt_nx;
      gnt_valid <= |gnt_nx;
      gnt_id    <= gnt_id_nx;
      tmo_o     <= tmo_o_nx;
      tmo_id    <= tmo_id_nx;
    end
  end

endmodule
